grf_write_arbiter: RTL and testbench

//  Write side of the GRF: merges two register-write sources onto the single GRF write port.

---
 rtl/grf_write_arbiter_pkg.sv | 13 +
 rtl/grf_write_arbiter_match.sv | 19 +
 rtl/grf_write_arbiter.sv | 128 ++++++++++++
 tb/tb_grf_write_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/grf_write_arbiter_pkg.sv
// Shared defaults and helpers for the GRF write arbiter and its late-write queue.
package grf_write_arbiter_pkg;

  localparam int unsigned WbqDepth = 4;
  localparam int unsigned WbqAw    = 5;
  localparam int unsigned WbqDw    = 32;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/grf_write_arbiter_match.sv
// Compares one query address against every queued destination; only live entries can hit.
module grf_write_arbiter_match #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5
) (
  input  logic [DEPTH-1:0][AW-1:0] a3_i,
  input  logic [DEPTH-1:0]         live_i,
  input  logic [AW-1:0]            addr_i,
  output logic [DEPTH-1:0]         hit_o
);

  always_comb begin
    hit_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_o[i] = live_i[i] && (a3_i[i] == addr_i);
    end
  end

endmodule

// File: rtl/grf_write_arbiter.sv
// Merges the W-stage write and a queued late-write path onto the single GRF write port.
// Define WB_TRACE_EN to print every GRF write in simulation.
module grf_write_arbiter
  import grf_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = WbqDepth,
  parameter int unsigned AW    = WbqAw,
  parameter int unsigned DW    = WbqDw
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     w_we_i,
  input  logic [AW-1:0]            w_a3_i,
  input  logic [DW-1:0]            w_wd_i,
  input  logic [DW-1:0]            w_pc_i,
  input  logic                     lw_valid_i,
  output logic                     lw_ready_o,
  input  logic [AW-1:0]            lw_a3_i,
  input  logic [DW-1:0]            lw_wd_i,
  input  logic [DW-1:0]            lw_pc_i,
  input  logic [AW-1:0]            q_a1_i,
  input  logic [AW-1:0]            q_a2_i,
  output logic                     busy1_o,
  output logic                     busy2_o,
  output logic                     grf_we_o,
  output logic [AW-1:0]            grf_a3_o,
  output logic [DW-1:0]            grf_wd_o,
  output logic [DW-1:0]            grf_pc_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  logic [DEPTH-1:0]         live_q, live_d;
  logic [DEPTH-1:0][AW-1:0] a3_q;
  logic [DEPTH-1:0][DW-1:0] wd_q, pc_q;
  logic [PW-1:0]            head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     w_act, accept, push, pop, head_fire;
  logic [DEPTH-1:0]         kill_hit, busy1_hit, busy2_hit;

  grf_write_arbiter_match #(.DEPTH(DEPTH), .AW(AW)) u_kill_match (
    .a3_i(a3_q), .live_i(live_q), .addr_i(w_a3_i), .hit_o(kill_hit)
  );
  grf_write_arbiter_match #(.DEPTH(DEPTH), .AW(AW)) u_busy1_match (
    .a3_i(a3_q), .live_i(live_q), .addr_i(q_a1_i), .hit_o(busy1_hit)
  );
  grf_write_arbiter_match #(.DEPTH(DEPTH), .AW(AW)) u_busy2_match (
    .a3_i(a3_q), .live_i(live_q), .addr_i(q_a2_i), .hit_o(busy2_hit)
  );

  always_comb begin
    // Reset also silences the W pass-through so the port is quiet while held.
    w_act      = rst_ni && w_we_i && (w_a3_i != '0);
    lw_ready_o = (count_q < CW'(DEPTH));
    accept     = lw_valid_i && lw_ready_o;
    // A late write to the register W is writing right now is already stale.
    push       = accept && (lw_a3_i != '0) && !(w_act && (lw_a3_i == w_a3_i));
    pop        = !w_act && (count_q != '0);
    head_fire  = pop && live_q[head_q];
  end

  always_comb begin
    grf_we_o = 1'b0;
    grf_a3_o = '0;
    grf_wd_o = '0;
    grf_pc_o = '0;
    if (w_act) begin
      grf_we_o = 1'b1;
      grf_a3_o = w_a3_i;
      grf_wd_o = w_wd_i;
      grf_pc_o = w_pc_i;
    end else if (head_fire) begin
      grf_we_o = 1'b1;
      grf_a3_o = a3_q[head_q];
      grf_wd_o = wd_q[head_q];
      grf_pc_o = pc_q[head_q];
    end
    busy1_o = (q_a1_i != '0) && (|busy1_hit);
    busy2_o = (q_a2_i != '0) && (|busy2_hit);
    count_o = count_q;
  end

  always_comb begin
    live_d = live_q;
    if (w_act) live_d = live_q & ~kill_hit;
    if (pop)   live_d[head_q] = 1'b0;
    if (push)  live_d[tail_q] = 1'b1;
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(push);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      live_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      live_q  <= live_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a3_q <= '0;
      wd_q <= '0;
      pc_q <= '0;
    end else if (push) begin
      a3_q[tail_q] <= lw_a3_i;
      wd_q[tail_q] <= lw_wd_i;
      pc_q[tail_q] <= lw_pc_i;
    end
  end

`ifdef WB_TRACE_EN
  always @(posedge clk_i) begin
    if (grf_we_o) $display("%d@%h: $%d <= %h", $time, grf_pc_o, grf_a3_o, grf_wd_o);
  end
`else
`endif

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Randomised scoreboard bench for grf_write_arbiter against a queue-based reference model.
module tb_grf_write_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        w_we_i = 1'b0;
  logic [4:0]  w_a3_i = '0;
  logic [31:0] w_wd_i = '0, w_pc_i = '0;
  logic        lw_valid_i = 1'b0;
  logic        lw_ready_o;
  logic [4:0]  lw_a3_i = '0;
  logic [31:0] lw_wd_i = '0, lw_pc_i = '0;
  logic [4:0]  q_a1_i = '0, q_a2_i = '0;
  logic        busy1_o, busy2_o, grf_we_o;
  logic [4:0]  grf_a3_o;
  logic [31:0] grf_wd_o, grf_pc_o;
  logic [2:0]  count_o;

  grf_write_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .w_we_i(w_we_i), .w_a3_i(w_a3_i), .w_wd_i(w_wd_i), .w_pc_i(w_pc_i),
    .lw_valid_i(lw_valid_i), .lw_ready_o(lw_ready_o),
    .lw_a3_i(lw_a3_i), .lw_wd_i(lw_wd_i), .lw_pc_i(lw_pc_i),
    .q_a1_i(q_a1_i), .q_a2_i(q_a2_i), .busy1_o(busy1_o), .busy2_o(busy2_o),
    .grf_we_o(grf_we_o), .grf_a3_o(grf_a3_o), .grf_wd_o(grf_wd_o), .grf_pc_o(grf_pc_o),
    .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
    bit          live;
  } ment_t;

  typedef struct {
    bit          we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
    bit          rdy;
    bit          b1;
    bit          b2;
    int unsigned cnt;
  } exp_t;

  ment_t mq[$];
  exp_t  expq[$];
  int    checks = 0;
  int    failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit busy_of(input logic [4:0] q);
    if (q == 0) return 1'b0;
    foreach (mq[i]) if (mq[i].live && mq[i].a3 == q) return 1'b1;
    return 1'b0;
  endfunction

  // One clock cycle of stimulus; the model's prediction for this cycle is queued.
  task automatic cyc(input bit rst, input bit wwe, input logic [4:0] wa3, input logic [31:0] wwd,
                     input bit lv, input logic [4:0] la3, input logic [31:0] lwd,
                     input logic [4:0] q1, input logic [4:0] q2);
    exp_t  e;
    ment_t h;
    bit    wact;
    int    n;
    logic [31:0] wpc, lpc;
    wpc = $urandom;
    lpc = $urandom;
    @(negedge clk_i);
    rst_ni = rst; w_we_i = wwe; w_a3_i = wa3; w_wd_i = wwd; w_pc_i = wpc;
    lw_valid_i = lv; lw_a3_i = la3; lw_wd_i = lwd; lw_pc_i = lpc;
    q_a1_i = q1; q_a2_i = q2;
    e = '{we: 0, a3: 0, wd: 0, pc: 0, rdy: 1, b1: 0, b2: 0, cnt: 0};
    if (!rst) begin
      mq.delete();
    end else begin
      wact  = wwe && (wa3 != 0);
      n     = mq.size();
      e.cnt = n;
      e.rdy = (n < 4);
      e.b1  = busy_of(q1);
      e.b2  = busy_of(q2);
      if (wact) begin
        e.we = 1; e.a3 = wa3; e.wd = wwd; e.pc = wpc;
        foreach (mq[i]) if (mq[i].a3 == wa3) mq[i].live = 0;
      end else if (n > 0) begin
        h = mq.pop_front();
        if (h.live) begin
          e.we = 1; e.a3 = h.a3; e.wd = h.wd; e.pc = h.pc;
        end
      end
      if (lv && e.rdy && la3 != 0 && !(wact && la3 == wa3))
        mq.push_back('{a3: la3, wd: lwd, pc: lpc, live: 1});
    end
    expq.push_back(e);
  endtask

  task automatic idle(input logic [4:0] q1);
    cyc(1, 0, 0, 0, 0, 0, 0, q1, 0);
  endtask

  // Monitor: compares the DUT against the oldest prediction, mid-cycle before the next edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      #2;
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("grf_we", 32'(grf_we_o), 32'(e.we));
        chk("grf_a3", 32'(grf_a3_o), 32'(e.a3));
        chk("grf_wd", grf_wd_o, e.wd);
        chk("grf_pc", grf_pc_o, e.pc);
        chk("lw_ready", 32'(lw_ready_o), 32'(e.rdy));
        chk("busy1", 32'(busy1_o), 32'(e.b1));
        chk("busy2", 32'(busy2_o), 32'(e.b2));
        chk("count", 32'(count_o), e.cnt);
      end
    end
  end

  initial begin
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Single late write drains next cycle; $8 busy for exactly one cycle.
    cyc(1, 0, 0, 0, 1, 8, 32'h1234, 8, 8);
    idle(8);
    idle(8);
    // Fill while W keeps the port busy, then drain in order.
    for (int r = 1; r <= 4; r++) cyc(1, 1, 9, $urandom, 1, 5'(r), $urandom, 5'(r), 1);
    cyc(1, 1, 9, $urandom, 1, 7, $urandom, 4, 3);
    for (int r = 1; r <= 5; r++) idle(5'(r));
    // W write kills a queued entry to the same register.
    cyc(1, 1, 9, 32'h1, 1, 5, 32'hAAAA, 5, 0);
    cyc(1, 1, 5, 32'hBBBB, 0, 0, 0, 5, 0);
    idle(5);
    idle(5);
    // Same-cycle lw and W to $6.
    cyc(1, 1, 6, 32'h6666, 1, 6, 32'hDEAD, 6, 0);
    idle(6);
    // Writes to $0 never reach the GRF.
    cyc(1, 0, 0, 0, 1, 0, 32'h5555, 0, 0);
    cyc(1, 1, 0, 32'h7777, 0, 0, 0, 0, 0);
    // Reset with three entries queued; W held active to show reset silences it.
    for (int r = 1; r <= 3; r++) cyc(1, 1, 9, $urandom, 1, 5'(r + 10), $urandom, 11, 12);
    cyc(0, 1, 9, 32'h9999, 0, 0, 0, 11, 12);
    for (int i = 0; i < 4; i++) idle(5'(11 + i));
    // Random traffic over a small register range to force collisions.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 149) != 0),
          ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
          ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom,
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    repeat (3) @(negedge clk_i);
    #4;
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
